// File: rtl/mult_adder_feeder_pkg.sv
// Shared constants, state type and helpers for the multiply-adder tree front end.
// Tree geometry defaults mirror the network-wide convolution parameters.
package mult_adder_feeder_pkg;

    localparam int MA_TREE_SIZE    = 16;
    localparam int CONV_MULT_WIDTH = 8;
    localparam int CONV_ADD_WIDTH  = 24;
    localparam int MA_LATENCY      = 1 + $clog2(MA_TREE_SIZE);

    typedef enum logic {
        KLOAD = 1'b0,
        RUN   = 1'b1
    } feeder_state_e;

    function automatic int unsigned ones(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mult_adder_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding tree sums; rd_data shows the head
// entry whenever empty is low, and count exposes the occupancy for credit tracking.
module mult_adder_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_rd;

    assign empty   = (count_q == '0);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: the storage array carries no reset; pointers and count alone define what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments so every register updates from its pre-edge value.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, do_rd})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Upstream credit must keep a push into a full FIFO from ever happening.
    no_overflow_a: assert property (@(posedge clock) disable iff (reset)
        !(wr_en && !do_rd && (count_q == CNT_FULL)));

endmodule

// File: rtl/mult_adder_feeder.sv
// Front end for the multiply-adder tree: serial kernel load, pixel gathering into
// operand vectors, fixed-latency tracking of the tree and a credited result FIFO.
module mult_adder_feeder
    import mult_adder_feeder_pkg::*;
#(
    parameter int TREE_SIZE  = MA_TREE_SIZE,
    parameter int MULT_WIDTH = CONV_MULT_WIDTH,
    parameter int ADD_WIDTH  = CONV_ADD_WIDTH,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    output logic                            ma_reset_n,
    input  logic                            kernel_load,
    input  logic [MULT_WIDTH-1:0]           kernel_word,
    output logic                            kernel_ready,
    output logic                            load_ready,
    input  logic                            pixel_valid,
    output logic                            pixel_ready,
    input  logic [MULT_WIDTH-1:0]           pixel_data,
    output logic [TREE_SIZE*MULT_WIDTH-1:0] ma_in,
    output logic [TREE_SIZE*MULT_WIDTH-1:0] ma_kernal,
    input  logic [ADD_WIDTH-1:0]            ma_out,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic [ADD_WIDTH-1:0]            result_data
);

    localparam int LATENCY     = 1 + $clog2(TREE_SIZE);
    // One extra stage accounts for the ma_in register sitting in front of the tree.
    localparam int TRACK_DEPTH = LATENCY + 1;
    localparam int IDX_W       = $clog2(TREE_SIZE);
    localparam int VEC_W       = TREE_SIZE * MULT_WIDTH;
    localparam int FCNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(TREE_SIZE - 1);

    feeder_state_e          state_q, state_d;
    logic [IDX_W-1:0]       kcnt_q, kcnt_d;
    logic [IDX_W-1:0]       pcnt_q, pcnt_d;
    logic                   kernel_ready_q, kernel_ready_d;
    logic [VEC_W-1:0]       kernel_q, kernel_d;
    logic [VEC_W-1:0]       gather_q, gather_d;
    logic [VEC_W-1:0]       ma_in_q, ma_in_d;
    logic [TRACK_DEPTH-1:0] inflight_q, inflight_d;

    logic [FCNT_W-1:0]      fifo_count;
    logic                   fifo_empty;
    int unsigned            outstanding;
    logic                   credit_ok;
    logic                   idle;
    logic                   load_fire;
    logic                   pixel_fire;
    logic                   issue;

    always_comb begin
        outstanding = 32'(fifo_count) + ones(32'(inflight_q));
        credit_ok   = outstanding < 32'(FIFO_DEPTH);
    end

    assign idle        = (pcnt_q == '0) && (inflight_q == '0) && fifo_empty;
    assign load_ready  = !reset && ((state_q == KLOAD) || idle);
    assign pixel_ready = !reset && (state_q == RUN) && !((pcnt_q == LAST) && !credit_ok);
    assign load_fire   = kernel_load && load_ready;
    assign pixel_fire  = pixel_valid && pixel_ready;
    assign issue       = pixel_fire && (pcnt_q == LAST);

    // NOTE: every _d takes its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        kcnt_d         = kcnt_q;
        pcnt_d         = pcnt_q;
        kernel_ready_d = kernel_ready_q;
        kernel_d       = kernel_q;
        gather_d       = gather_q;
        ma_in_d        = ma_in_q;
        inflight_d     = {inflight_q[TRACK_DEPTH-2:0], issue};

        if (load_fire) begin
            if (state_q == KLOAD) begin
                kernel_d[int'(kcnt_q)*MULT_WIDTH +: MULT_WIDTH] = kernel_word;
                kcnt_d = kcnt_q + IDX_W'(1);
                if (kcnt_q == LAST) begin
                    state_d        = RUN;
                    kernel_ready_d = 1'b1;
                end
            end else begin
                state_d        = KLOAD;
                kcnt_d         = '0;
                kernel_ready_d = 1'b0;
            end
        end

        if (pixel_fire) begin
            gather_d[int'(pcnt_q)*MULT_WIDTH +: MULT_WIDTH] = pixel_data;
            pcnt_d = pcnt_q + IDX_W'(1);
            if (issue) begin
                ma_in_d = gather_d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= KLOAD;
            kcnt_q         <= '0;
            pcnt_q         <= '0;
            kernel_ready_q <= 1'b0;
            kernel_q       <= '0;
            gather_q       <= '0;
            ma_in_q        <= '0;
            inflight_q     <= '0;
        end else begin
            state_q        <= state_d;
            kcnt_q         <= kcnt_d;
            pcnt_q         <= pcnt_d;
            kernel_ready_q <= kernel_ready_d;
            kernel_q       <= kernel_d;
            gather_q       <= gather_d;
            ma_in_q        <= ma_in_d;
            inflight_q     <= inflight_d;
        end
    end

    mult_adder_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADD_WIDTH)
    ) u_result_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (inflight_q[TRACK_DEPTH-1]),
        .wr_data (ma_out),
        .rd_en   (result_ready),
        .rd_data (result_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign ma_reset_n   = ~reset;
    assign kernel_ready = kernel_ready_q;
    assign ma_in        = ma_in_q;
    assign ma_kernal    = kernel_q;
    assign result_valid = !fifo_empty;

endmodule

// File: tb/tb_mult_adder_feeder.sv
// Randomized bench for mult_adder_feeder: a behavioural tree drives ma_out, and a
// window-level model predicts handshakes and the ordered stream of window sums.
module tb_mult_adder_feeder;

    localparam int TS  = 16;
    localparam int MW  = 8;
    localparam int AW  = 24;
    localparam int FD  = 8;
    localparam int LAT = 1 + $clog2(TS);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ma_reset_n;
    logic              kernel_load = 1'b0;
    logic [MW-1:0]     kernel_word = '0;
    logic              kernel_ready;
    logic              load_ready;
    logic              pixel_valid = 1'b0;
    logic              pixel_ready;
    logic [MW-1:0]     pixel_data = '0;
    logic [TS*MW-1:0]  ma_in;
    logic [TS*MW-1:0]  ma_kernal;
    logic [AW-1:0]     ma_out;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic [AW-1:0]     result_data;

    always #5 clock = ~clock;

    mult_adder_feeder #(
        .TREE_SIZE  (TS),
        .MULT_WIDTH (MW),
        .ADD_WIDTH  (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ma_reset_n   (ma_reset_n),
        .kernel_load  (kernel_load),
        .kernel_word  (kernel_word),
        .kernel_ready (kernel_ready),
        .load_ready   (load_ready),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .pixel_data   (pixel_data),
        .ma_in        (ma_in),
        .ma_kernal    (ma_kernal),
        .ma_out       (ma_out),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data)
    );

    // Behavioural tree: sum of lane products, delayed by LAT registered stages.
    logic [AW-1:0] tree_sum;
    logic [AW-1:0] tree_pipe [LAT];

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < TS; i++) begin
            tree_sum = tree_sum + AW'(ma_in[i*MW +: MW]) * AW'(ma_kernal[i*MW +: MW]);
        end
    end

    always_ff @(posedge clock) begin
        tree_pipe[0] <= tree_sum;
        for (int i = 1; i < LAT; i++) begin
            tree_pipe[i] <= tree_pipe[i-1];
        end
    end

    assign ma_out = tree_pipe[LAT-1];

    // Reference model state.
    int            n_checks = 0;
    int            n_bad    = 0;
    bit            m_kload;
    int            m_kcnt;
    logic [MW-1:0] m_kernel [TS];
    logic [MW-1:0] m_win [$];
    logic [AW-1:0] exp_q [$];
    int            n_issued = 0;
    int            n_popped = 0;

    task automatic check(input string tag, input logic [TS*MW-1:0] got, input logic [TS*MW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] window_sum();
        logic [AW-1:0] s;
        s = '0;
        for (int i = 0; i < TS; i++) begin
            s = s + AW'(m_win[i]) * AW'(m_kernel[i]);
        end
        return s;
    endfunction

    function automatic logic [TS*MW-1:0] model_kernel_vec();
        logic [TS*MW-1:0] v;
        v = '0;
        for (int i = 0; i < TS; i++) begin
            v[i*MW +: MW] = m_kernel[i];
        end
        return v;
    endfunction

    // One clock: check at the falling edge, advance the model, return 1 time unit after the rise.
    task automatic tick();
        bit px;
        bit kl;
        bit pop;
        @(negedge clock);
        check("pixel_ready", pixel_ready, !m_kload && !(m_win.size() == TS-1 && exp_q.size() >= FD));
        check("load_ready", load_ready, m_kload || (m_win.size() == 0 && exp_q.size() == 0));
        check("kernel_ready", kernel_ready, !m_kload);
        if (exp_q.size() == 0) check("idle_result_valid", result_valid, 1'b0);
        px  = pixel_valid && pixel_ready;
        kl  = kernel_load && load_ready;
        pop = result_valid && result_ready;
        if (pop) begin
            if (exp_q.size() > 0) check("result_data", result_data, exp_q.pop_front());
            else                  check("spurious_result", result_valid, 1'b0);
            n_popped++;
        end
        if (kl) begin
            if (m_kload) begin
                m_kernel[m_kcnt] = kernel_word;
                m_kcnt++;
                if (m_kcnt == TS) m_kload = 1'b0;
            end else begin
                m_kload = 1'b1;
                m_kcnt  = 0;
            end
        end
        if (px) begin
            m_win.push_back(pixel_data);
            if (m_win.size() == TS) begin
                exp_q.push_back(window_sum());
                m_win.delete();
                n_issued++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int edges);
        kernel_load  = 1'b0;
        pixel_valid  = 1'b0;
        reset        = 1'b1;
        repeat (edges) @(posedge clock);
        #1;
        check("rst_ma_reset_n", ma_reset_n, 1'b0);
        check("rst_load_ready", load_ready, 1'b0);
        check("rst_pixel_ready", pixel_ready, 1'b0);
        check("rst_kernel_ready", kernel_ready, 1'b0);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_ma_in", ma_in, '0);
        check("rst_ma_kernal", ma_kernal, '0);
        reset   = 1'b0;
        m_kload = 1'b1;
        m_kcnt  = 0;
        for (int i = 0; i < TS; i++) m_kernel[i] = '0;
        m_win.delete();
        exp_q.delete();
    endtask

    // mode 0: weights 1..TS, mode 1: random, otherwise the constant (mode - 2).
    task automatic load_kernel(input int mode);
        if (!m_kload) begin
            kernel_load = 1'b1;
            kernel_word = MW'($urandom);
            tick();
            check("reload_kernel_ready", kernel_ready, 1'b0);
        end
        for (int i = 0; i < TS; i++) begin
            kernel_load = 1'b1;
            kernel_word = (mode == 0) ? MW'(i + 1) : (mode == 1) ? MW'($urandom) : MW'(mode - 2);
            tick();
        end
        kernel_load = 1'b0;
        check("loaded_kernel", ma_kernal, model_kernel_vec());
    endtask

    // rmode 0/1: fixed result_ready, 2: random; fixed < 0 selects random pixel data.
    task automatic stream(input int nwin, input int vpct, input int rmode, input int fixed);
        int target;
        int b;
        target = n_issued + nwin;
        b = 0;
        while (n_issued < target && b < 3000) begin
            pixel_valid  = ($urandom_range(99) < vpct);
            pixel_data   = (fixed < 0) ? MW'($urandom) : MW'(fixed);
            result_ready = (rmode == 2) ? 1'($urandom_range(1)) : 1'(rmode);
            tick();
            b++;
        end
        pixel_valid = 1'b0;
        check("stream_issued", n_issued, target);
    endtask

    task automatic drain();
        int b;
        b = 0;
        result_ready = 1'b1;
        pixel_valid  = 1'b0;
        while (exp_q.size() > 0 && b < 200) begin
            tick();
            b++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        int i0;
        int b;

        // Reset state, then weights 1..16 and a single window of 2s.
        do_reset(2);
        load_kernel(0);
        check("kernel_lane0", ma_kernal[0 +: MW], 8'd1);
        check("kernel_lane15", ma_kernal[15*MW +: MW], 8'd16);
        result_ready = 1'b0;
        for (int i = 0; i < TS; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = 8'd2;
            tick();
        end
        pixel_valid = 1'b0;
        check("ma_in_lane0", ma_in[0 +: MW], 8'd2);
        check("ma_in_lane15", ma_in[15*MW +: MW], 8'd2);
        n = 0;
        while (!result_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("first_latency", n, LAT + 1);
        check("first_sum", result_data, 24'd272);
        drain();

        // Continuous stream with the consumer always ready.
        p0 = n_popped;
        stream(4, 100, 1, -1);
        drain();
        check("tp_results", n_popped - p0, 4);

        // Back-pressure: credit stalls the last pixel once FD windows are outstanding.
        p0 = n_popped;
        i0 = n_issued;
        result_ready = 1'b0;
        repeat (FD*TS + TS - 1 + 6) begin
            pixel_valid = 1'b1;
            pixel_data  = MW'($urandom);
            tick();
        end
        check("bp_stall", pixel_ready, 1'b0);
        check("bp_issued", n_issued - i0, FD);
        result_ready = 1'b1;
        b = 0;
        while (n_issued - i0 < FD + 1 && b < 200) begin
            pixel_valid = 1'b1;
            pixel_data  = MW'($urandom);
            tick();
            b++;
        end
        drain();
        check("bp_results", n_popped - p0, FD + 1);

        // kernel_load mid-window is ignored; after the drain it is accepted.
        repeat (TS/2) begin
            pixel_valid = 1'b1;
            pixel_data  = MW'($urandom);
            tick();
        end
        pixel_valid = 1'b0;
        kernel_load = 1'b1;
        kernel_word = 8'h55;
        tick();
        kernel_load = 1'b0;
        check("filter_kernel", ma_kernal, model_kernel_vec());
        b = 0;
        while (m_win.size() != 0 && b < 100) begin
            pixel_valid = 1'b1;
            pixel_data  = MW'($urandom);
            tick();
            b++;
        end
        drain();
        load_kernel(1);

        // Random valid/ready traffic.
        stream(6, 70, 2, -1);
        drain();

        // Largest operands pass through unmodified.
        load_kernel(2 + 255);
        stream(1, 100, 0, 255);
        drain();

        // Reset with work in flight and queued: nothing stale may emerge.
        load_kernel(1);
        stream(4, 100, 0, -1);
        do_reset(1);
        result_ready = 1'b1;
        repeat (20) tick();
        load_kernel(1);
        stream(2, 90, 2, -1);
        drain();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
